// File: rtl/down_counter_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_timer_if
// Description : Control/status bundle for the loadable down-counter/timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface down_counter_timer_if #(
    parameter int N = 8
);
    logic         load;
    logic [N-1:0] init_val;
    logic         start;
    logic         hold;
    logic         auto_reload;
    logic [N-1:0] valor;
    logic         busy;
    logic         done;
    logic         zero;

    modport master (
        output load, init_val, start, hold, auto_reload,
        input  valor, busy, done, zero
    );

    modport slave (
        input  load, init_val, start, hold, auto_reload,
        output valor, busy, done, zero
    );
endinterface
`default_nettype wire

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_timer
// Description : Loadable N-bit down-counter/timer with one-shot/auto-reload
//               modes and hold. Optional tick prescaler enabled by defining
//               DOWN_COUNTER_TIMER_PRESCALER_EN (divide ratio PRESC).
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
    parameter int N     = 8,
    parameter int PRESC = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    down_counter_timer_if.slave  bus
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]   r_state;
    logic [N-1:0] r_valor;
    logic [N-1:0] r_reload;
    logic         r_done;
    logic         w_tick;

    generate
        if (PRESC < 2) begin : g_presc_bad
            $error("down_counter_timer: PRESC must be at least 2");
        end
    endgenerate

`ifdef DOWN_COUNTER_TIMER_PRESCALER_EN
    localparam int             c_PW   = $clog2(PRESC);
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESC - 1);

    logic [c_PW-1:0] r_presc;

    assign w_tick = (r_state == c_ST_RUN) && !bus.hold && (r_presc == c_PMAX);

    // Held at zero in IDLE, which also covers the clear on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (bus.load || (r_state == c_ST_IDLE)) begin
            r_presc <= '0;
        end else if (!bus.hold) begin
            r_presc <= (r_presc == c_PMAX) ? '0 : r_presc + c_PW'(1);
        end
    end
`else
    assign w_tick = (r_state == c_ST_RUN) && !bus.hold;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_valor  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.load) begin
                r_valor  <= bus.init_val;
                r_reload <= bus.init_val;
                r_state  <= c_ST_IDLE;
            end else if (r_state == c_ST_IDLE) begin
                if (bus.start && (r_valor != '0)) begin
                    r_state <= c_ST_RUN;
                end
            end else if (w_tick) begin
                if (r_valor > N'(1)) begin
                    r_valor <= r_valor - N'(1);
                end else if (r_valor == N'(1)) begin
                    // Terminal tick: auto-reload skips the zero value entirely.
                    r_done <= 1'b1;
                    if (bus.auto_reload) begin
                        r_valor <= r_reload;
                    end else begin
                        r_valor <= '0;
                        r_state <= c_ST_IDLE;
                    end
                end else begin
                    r_state <= c_ST_IDLE;
                end
            end
        end
    end

    assign bus.valor = r_valor;
    assign bus.busy  = (r_state == c_ST_RUN);
    assign bus.done  = r_done;
    assign bus.zero  = (r_valor == '0);

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter_timer
// Description : Directed bench with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_timer;

    localparam int N     = 8;
    localparam int PRESC = 4;
`ifdef DOWN_COUNTER_TIMER_PRESCALER_EN
    localparam int c_DIV = PRESC;
`else
    localparam int c_DIV = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    down_counter_timer_if #(.N(N)) bus ();

    down_counter_timer #(.N(N), .PRESC(PRESC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a timer that spends c_DIV unheld run cycles per unit.
    int m_val, m_rel, m_phase;
    bit m_run, m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val <= 0; m_rel <= 0; m_phase <= 0; m_run <= 0; m_done <= 0;
        end else begin
            m_done <= 0;
            if (bus.load) begin
                m_val <= int'(bus.init_val); m_rel <= int'(bus.init_val);
                m_run <= 0; m_phase <= 0;
            end else if (!m_run) begin
                if (bus.start && m_val > 0) begin
                    m_run <= 1; m_phase <= 0;
                end
            end else if (!bus.hold) begin
                if (m_phase + 1 < c_DIV) begin
                    m_phase <= m_phase + 1;
                end else begin
                    m_phase <= 0;
                    if (m_val > 1) m_val <= m_val - 1;
                    else begin
                        m_done <= 1;
                        if (bus.auto_reload) m_val <= m_rel;
                        else begin m_val <= 0; m_run <= 0; end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("cyc.valor", 32'(bus.valor), 32'(m_val));
            chk("cyc.busy",  32'(bus.busy),  32'(m_run));
            chk("cyc.done",  32'(bus.done),  32'(m_done));
            chk("cyc.zero",  32'(bus.zero),  32'(m_val == 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int v, input int b, input int d);
        chk({name, ".valor"}, 32'(bus.valor), 32'(v));
        chk({name, ".busy"},  32'(bus.busy),  32'(b));
        chk({name, ".done"},  32'(bus.done),  32'(d));
        chk({name, ".zero"},  32'(bus.zero),  32'(v == 0));
    endtask

    task automatic do_load(input int v);
        bus.load = 1'b1;
        bus.init_val = N'(v);
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst = 1'b1;
        bus.load = 1'b0; bus.init_val = '0; bus.start = 1'b0;
        bus.hold = 1'b0; bus.auto_reload = 1'b0;
        repeat (2) step();
        expect_out("reset", 0, 0, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

`ifndef DOWN_COUNTER_TIMER_PRESCALER_EN
        // One-shot from 3
        do_load(3);              expect_out("t1_load", 3, 0, 0);
        do_start();              expect_out("t1_e0", 3, 1, 0);
        step();                  expect_out("t1_e1", 2, 1, 0);
        step();                  expect_out("t1_e2", 1, 1, 0);
        step();                  expect_out("t1_e3", 0, 0, 1);
        chk("model_t1", 32'(m_val), 32'd0);
        step();                  expect_out("t1_after", 0, 0, 0);

        // Auto-reload from 2
        bus.auto_reload = 1'b1;
        do_load(2);
        do_start();              expect_out("t2_e0", 2, 1, 0);
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (bus.done) pulses++;
            expect_out("t2_run", (i % 2 == 1) ? 1 : 2, 1, (i % 2 == 0) ? 1 : 0);
        end
        chk("t2_pulses", 32'(pulses), 32'd3);
        chk("model_t2", 32'(m_val), 32'd2);
        bus.auto_reload = 1'b0;
        do_load(0);              expect_out("t2_abort", 0, 0, 0);

        // Hold for 4 cycles after the second decrement
        do_load(5);
        do_start();              expect_out("t3_e0", 5, 1, 0);
        step();                  expect_out("t3_e1", 4, 1, 0);
        step();                  expect_out("t3_e2", 3, 1, 0);
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();              expect_out("t3_hold", 3, 1, 0);
        end
        bus.hold = 1'b0;
        step();                  expect_out("t3_e7", 2, 1, 0);
        step();                  expect_out("t3_e8", 1, 1, 0);
        step();                  expect_out("t3_e9", 0, 0, 1);
`else
        // Prescaled one-shot from 2: one decrement every PRESC cycles
        do_load(2);
        do_start();              expect_out("t6_e0", 2, 1, 0);
        for (int i = 1; i < PRESC; i++) begin
            step();              expect_out("t6_wait1", 2, 1, 0);
        end
        step();                  expect_out("t6_e4", 1, 1, 0);
        chk("model_t6", 32'(m_val), 32'd1);
        for (int i = 1; i < PRESC; i++) begin
            step();              expect_out("t6_wait2", 1, 1, 0);
        end
        step();                  expect_out("t6_e8", 0, 0, 1);
        step();                  expect_out("t6_after", 0, 0, 0);
`endif

        // Abort by load, start on zero, load beats start, hold in IDLE
        do_load(6);
        do_start();
        step(); step();
        do_load(9);              expect_out("t4_abort", 9, 0, 0);
        step();                  expect_out("t4_nodone", 9, 0, 0);
        do_load(0);              expect_out("t4_load0", 0, 0, 0);
        do_start();              expect_out("t4_start0", 0, 0, 0);
        step();                  expect_out("t4_idle0", 0, 0, 0);
        bus.start = 1'b1;
        do_load(4);
        bus.start = 1'b0;        expect_out("t4_ld_st", 4, 0, 0);
        bus.hold = 1'b1;
        step();                  expect_out("t4_hold_idle", 4, 0, 0);
        bus.hold = 1'b0;

        // Asynchronous reset mid-run
        do_load(7);
        do_start();
        step(); step();
        chk("t5_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1 expect_out("t5_async", 0, 0, 0);
        #1 rst = 1'b0;
        do_start();              expect_out("t5_start0", 0, 0, 0);
        step();                  expect_out("t5_idle", 0, 0, 0);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable N-bit down-counter/timer: the complement of the free-running up counter. It counts a programmed value down to zero and signals expiry.
- One-shot and auto-reload modes, with a count-hold input.
- Feeds timeouts and periodic ticks to the controllers in the lab designs.
- Single clock domain, no handshake beyond level/pulse control signals.

Parameters:
- N, 8, width of count value and load value.
- PRESC, 4, tick divide ratio (≥2); used only when the prescaler option is compiled in.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  copy init_val into count and reload registers; abort any run.
- init_val  input  N  value captured on load.
- start  input  1  begin counting from current valor (IDLE only).
- hold  input  1  freeze counting while high (RUN only).
- auto_reload  input  1  mode, sampled at each terminal tick: 1 = reload and continue, 0 = stop.
- valor  output  N  current count, registered.
- busy  output  1  high while in RUN, registered.
- done  output  1  one-cycle pulse on terminal count, registered.
- zero  output  1  combinational, valor == 0.

Behaviour:
- Reset (async, any state): state=IDLE, valor=0, reload=0, busy=0, done=0, prescaler=0. The outputs change immediately, without waiting for clk.
- States:
  - IDLE: not counting.
  - RUN: counting.
  - Only these two; busy = (state==RUN).
- done defaults to 0 every cycle; it is high only in the cycle following a terminal tick.
- Priority each edge: load > start > tick.
- load (any state): valor<=init_val, reload<=init_val, state<=IDLE, prescaler cleared, done=0.
  - An aborted run never produces done.
- start in IDLE with valor!=0 and load=0: state<=RUN, prescaler cleared.
  - No decrement on the start edge.
- start in IDLE with valor==0: ignored, stays IDLE, no done.
- start in RUN: ignored.
- Tick: every clk edge in RUN (or every PRESC edges with prescaler), only when hold=0.
- Normal tick, valor>1: valor<=valor-1.
- Terminal tick, valor==1:
  - done<=1.
  - auto_reload=0: valor<=0, state<=IDLE; busy falls on the same edge.
  - auto_reload=1: valor<=reload, stay RUN; valor never shows 0.
- hold=1 in RUN:
  - No decrement, no done.
  - Prescaler frozen.
  - busy stays 1.
- Latency: start on edge E0 with valor=V, no hold, no prescaler.
  - Decrements occur at E1..EV.
  - done is high in the cycle after EV.
  - Auto-reload period = V cycles.
  - Each hold cycle adds one cycle.
- valor never underflows; no wrap below 0.
- hold in IDLE has no effect.
- A later load of 0 followed by start is ignored.
- Arithmetic is N-bit unsigned; reload is held in an internal N-bit register.

Optional Feature:
- Macro: DOWN_COUNTER_TIMER_PRESCALER_EN.
- Defined:
  - Adds an internal prescaler of width clog2(PRESC).
  - A tick occurs when prescaler==PRESC-1 and hold=0; the prescaler then returns to 0.
  - The prescaler increments each RUN cycle with hold=0.
  - Cleared on rst, load and start.
  - Expiry latency = V*PRESC cycles after start.
- Undefined: no prescaler logic; every RUN cycle with hold=0 is a tick; PRESC ignored.

Test Plan:
- load init_val=3, start, auto_reload=0, hold=0 -> valor 3,2,1,0 on successive edges; done high exactly one cycle, coincident with valor=0; busy 1 for 3 cycles then 0; zero=1 afterwards.
- load 2, start, auto_reload=1 held 6 cycles -> valor 2,1,2,1,2,1; done pulses every 2 cycles (3 pulses); busy stays 1.
- load 5, start, hold=1 for 4 cycles after the second decrement -> valor stays 3 for 4 cycles; done appears 9 cycles after start instead of 5.
- load 6, start, load init_val=9 at valor=4 -> valor=9, IDLE, busy=0, no done. load 0, then start -> stays IDLE, no done. load+start in the same cycle -> load wins, no RUN.
- Running at valor=5, assert rst between clk edges -> valor=0, busy=0, done=0 before the next edge. After release, start with valor=0 is ignored.
- DOWN_COUNTER_TIMER_PRESCALER_EN defined, PRESC=4, load 2, start, auto_reload=0 -> valor changes every 4 cycles (2→1→0); done 8 cycles after start.
